// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: streams instruction-memory words into a small
// prefetch FIFO and presents them as valid/ready commands until HALT or address overflow.
module instr_fetch_unit #(
   parameter int ADDR_W       = 10,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   instr_count,
   output logic [ADDR_W-1:0] instruction_mem_address,
   output logic              instruction_mem_chipselect,
   output logic              instruction_mem_clken,
   output logic              instruction_mem_write,
   output logic [31:0]       instruction_mem_writedata,
   output logic [3:0]        instruction_mem_byteenable,
   input  logic [31:0]       instruction_mem_readdata,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [3:0]        cmd_opcode,
   output logic [27:0]       cmd_operand
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   state_t                  r_state;
   logic [ADDR_W-1:0]       r_pc;
   logic [CNT_W-1:0]        r_inflight;
   logic [READ_LATENCY-1:0] r_rd_vld;
   logic                    r_halt;
   logic                    r_ovf;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_error;
   logic [ADDR_W:0]         r_instr_count;
   logic [31:0]             r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wptr;
   logic [PTR_W-1:0]        r_rptr;
   logic [CNT_W-1:0]        r_occ;

   logic                    w_active;
   logic                    w_ret;
   logic                    w_ret_halt;
   logic                    w_push;
   logic                    w_pop;
   logic [CNT_W:0]          w_used;
   logic                    w_issue;
   logic [CNT_W-1:0]        w_inflight_nxt;
   logic [CNT_W-1:0]        w_occ_nxt;
   logic                    w_halt_nxt;
   logic                    w_ovf_nxt;
   logic                    w_runs_out;
   logic                    w_stop;
   logic                    w_finish;
   logic [31:0]             w_head;

   assign w_active   = (r_state == S_FETCH) || (r_state == S_DRAIN);
   assign w_ret      = r_rd_vld[READ_LATENCY-1];
   // Only the first HALT counts; anything returned after it is dropped.
   assign w_ret_halt = w_ret & ~r_halt & (instruction_mem_readdata[31:28] == 4'h0);
   assign w_push     = w_ret & ~r_halt & (instruction_mem_readdata[31:28] != 4'h0);
   assign w_pop      = (r_occ != '0) & cmd_ready;
   assign w_used     = (CNT_W+1)'(r_inflight) + (CNT_W+1)'(r_occ);
   assign w_issue    = (r_state == S_FETCH) & ~r_halt & ~r_ovf & (w_used < DEPTH_L);

   assign w_inflight_nxt = r_inflight + CNT_W'(w_issue) - CNT_W'(w_ret);
   assign w_occ_nxt      = r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_halt_nxt     = r_halt | w_ret_halt;
   assign w_ovf_nxt      = r_ovf | (w_issue & (r_pc == {ADDR_W{1'b1}}));
   assign w_runs_out     = w_ovf_nxt & ~w_halt_nxt & (w_inflight_nxt == '0);
   assign w_stop         = w_halt_nxt | w_runs_out;
   assign w_finish       = w_stop & (w_inflight_nxt == '0) & (w_occ_nxt == '0);

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state       <= S_IDLE;
         r_pc          <= '0;
         r_inflight    <= '0;
         r_rd_vld      <= '0;
         r_halt        <= 1'b0;
         r_ovf         <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
         r_instr_count <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_occ         <= '0;
      end else begin
         r_done      <= 1'b0;
         r_rd_vld[0] <= w_issue;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_rd_vld[i] <= r_rd_vld[i-1];
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state       <= S_FETCH;
                  r_pc          <= start_addr;
                  r_inflight    <= '0;
                  r_halt        <= 1'b0;
                  r_ovf         <= 1'b0;
                  r_busy        <= 1'b1;
                  r_error       <= 1'b0;
                  r_instr_count <= '0;
                  r_wptr        <= '0;
                  r_rptr        <= '0;
                  r_occ         <= '0;
               end
            end
            default: begin
               if (w_issue) r_pc <= r_pc + ADDR_W'(1);
               if (w_push)  r_wptr <= r_wptr + PTR_W'(1);
               if (w_pop) begin
                  r_rptr        <= r_rptr + PTR_W'(1);
                  r_instr_count <= r_instr_count + (ADDR_W+1)'(1);
               end
               r_inflight <= w_inflight_nxt;
               r_occ      <= w_occ_nxt;
               r_halt     <= w_halt_nxt;
               r_ovf      <= w_ovf_nxt;
               if (w_runs_out) r_error <= 1'b1;
               if (w_finish) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (w_stop) begin
                  r_state <= S_DRAIN;
               end
            end
         endcase
      end
   end

   // Prefetch storage holds data only; validity lives in the pointers above.
   always_ff @(posedge clk_clk) begin
      if (w_push && w_active) r_fifo[r_wptr] <= instruction_mem_readdata;
   end

   assign w_head = r_fifo[r_rptr];

   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;
   assign instr_count = r_instr_count;

   assign instruction_mem_address    = r_pc;
   assign instruction_mem_chipselect = w_issue;
   assign instruction_mem_clken      = 1'b1;
   assign instruction_mem_write      = 1'b0;
   assign instruction_mem_writedata  = 32'h0;
   assign instruction_mem_byteenable = 4'hF;

   assign cmd_valid   = (r_occ != '0);
   assign cmd_opcode  = cmd_valid ? w_head[31:28] : 4'h0;
   assign cmd_operand = cmd_valid ? w_head[27:0]  : 28'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  start_addr = '0;
   logic        busy, done, error;
   logic [10:0] instr_count;
   logic [9:0]  address;
   logic        cs, clken, wr;
   logic [31:0] wdata;
   logic [3:0]  ben;
   logic [31:0] rdata;
   logic        cmd_valid;
   logic        cmd_ready = 1'b1;
   logic [3:0]  opcode;
   logic [27:0] operand;

   instr_fetch_unit dut (
      .clk_clk                    (clk),
      .reset_reset                (rst),
      .start                      (start),
      .start_addr                 (start_addr),
      .busy                       (busy),
      .done                       (done),
      .error                      (error),
      .instr_count                (instr_count),
      .instruction_mem_address    (address),
      .instruction_mem_chipselect (cs),
      .instruction_mem_clken      (clken),
      .instruction_mem_write      (wr),
      .instruction_mem_writedata  (wdata),
      .instruction_mem_byteenable (ben),
      .instruction_mem_readdata   (rdata),
      .cmd_valid                  (cmd_valid),
      .cmd_ready                  (cmd_ready),
      .cmd_opcode                 (opcode),
      .cmd_operand                (operand)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Two-cycle read-latency memory
   logic [31:0] mem [0:1023];
   logic [31:0] m1, rd;
   logic        v1, v2;
   assign rdata = rd;

   // Reference model state
   int          cyc = 0;
   bit          run_active, halt_m, ovf_m, exp_done, exp_err;
   int          pc_m, out_m, cnt_m, cs_count, valid_cyc;
   int          start_cyc, first_valid, first_pop, last_pop;
   logic [31:0] q[$];
   logic [31:0] got[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0; v2 <= 1'b0; m1 <= '0; rd <= '0;
         run_active = 0; halt_m = 0; ovf_m = 0; exp_done = 0; exp_err = 0;
         pc_m = 0; out_m = 0; cnt_m = 0;
         q.delete();
      end else begin
         exp_done = 0;
         if (run_active) begin
            if (cmd_valid) begin
               valid_cyc++;
               if (first_valid < 0) first_valid = cyc;
            end
            if (cmd_valid && cmd_ready) begin
               got.push_back({opcode, operand});
               if (first_pop < 0) first_pop = cyc;
               last_pop = cyc;
               if (q.size() > 0) void'(q.pop_front());
               cnt_m++;
            end
            if (cs) begin
               cs_count++;
               out_m++;
               if (address == 10'd1023) ovf_m = 1;
               pc_m = (pc_m + 1) % 1024;
            end
            if (v2) begin
               out_m--;
               if (!halt_m) begin
                  if (rd[31:28] == 4'h0) halt_m = 1;
                  else q.push_back(rd);
               end
            end
            if (ovf_m && !halt_m && out_m == 0) exp_err = 1;
            if ((halt_m || ovf_m) && out_m == 0 && q.size() == 0) begin
               exp_done   = 1;
               run_active = 0;
            end
         end else if (start) begin
            run_active = 1;
            pc_m = int'(start_addr);
            out_m = 0; cnt_m = 0; halt_m = 0; ovf_m = 0; exp_err = 0;
            cs_count = 0; valid_cyc = 0;
            start_cyc = cyc; first_valid = -1; first_pop = -1; last_pop = -1;
            q.delete();
            got.delete();
         end
         v1 <= cs;
         m1 <= mem[address];
         v2 <= v1;
         rd <= m1;
         cyc++;
      end
   end

   bit exp_cs;
   always @(negedge clk) begin
      if (!rst) begin
         exp_cs = run_active && !halt_m && !ovf_m && (out_m + q.size() < 4);
         chk("chipselect", 64'(cs), 64'(exp_cs));
         if (exp_cs) chk("address", 64'(address), 64'(pc_m));
         chk("cmd_valid", 64'(cmd_valid), 64'(q.size() > 0));
         if (q.size() > 0) chk("payload", 64'({opcode, operand}), 64'(q[0]));
         chk("instr_count", 64'(instr_count), 64'(cnt_m));
         chk("busy", 64'(busy), 64'(run_active));
         chk("done", 64'(done), 64'(exp_done));
         chk("error", 64'(error), 64'(exp_err));
      end
   end

   task automatic pulse_start(input logic [9:0] a);
      @(negedge clk);
      start = 1'b1;
      start_addr = a;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int limit);
      bit seen = 0;
      for (int i = 0; i < limit; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      chk(nm, 64'(seen), 64'd1);
   endtask

   task automatic check_idle_outputs(input string nm);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_done"}, 64'(done), 64'd0);
      chk({nm, "_error"}, 64'(error), 64'd0);
      chk({nm, "_cs"}, 64'(cs), 64'd0);
      chk({nm, "_addr"}, 64'(address), 64'd0);
      chk({nm, "_count"}, 64'(instr_count), 64'd0);
      chk({nm, "_valid"}, 64'(cmd_valid), 64'd0);
      chk({nm, "_payload"}, 64'({opcode, operand}), 64'd0);
      chk({nm, "_write"}, 64'(wr), 64'd0);
      chk({nm, "_wdata"}, 64'(wdata), 64'd0);
      chk({nm, "_clken"}, 64'(clken), 64'd1);
      chk({nm, "_ben"}, 64'(ben), 64'hF);
   endtask

   task automatic basic_run(input string nm);
      cmd_ready = 1'b1;
      pulse_start(10'd0);
      wait_done({nm, "_done"}, 100);
      chk({nm, "_ncmd"}, 64'(got.size()), 64'd2);
      if (got.size() == 2) begin
         chk({nm, "_cmd0"}, 64'(got[0]), 64'h1000_0005);
         chk({nm, "_cmd1"}, 64'(got[1]), 64'h2000_0007);
      end
      chk({nm, "_count"}, 64'(instr_count), 64'd2);
      chk({nm, "_error"}, 64'(error), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = {4'h7, 28'(i)};
      mem[0] = 32'h1000_0005;
      mem[1] = 32'h2000_0007;
      mem[2] = 32'h0000_0000;
      for (int k = 0; k < 8; k++) mem[100 + k] = 32'h3000_0000 + 32'(k);
      mem[108] = 32'h0;
      for (int k = 0; k < 16; k++) mem[200 + k] = 32'h5000_0000 + 32'(k);
      mem[216] = 32'h0;
      mem[500] = 32'h0;

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b0;

      basic_run("basic");

      // Backpressure: engine stalls for 12 cycles
      cmd_ready = 1'b0;
      pulse_start(10'd100);
      repeat (11) @(negedge clk);
      chk("bp_reads", 64'(cs_count), 64'd4);
      chk("bp_valid", 64'(cmd_valid), 64'd1);
      chk("bp_head", 64'({opcode, operand}), 64'h3000_0000);
      cmd_ready = 1'b1;
      wait_done("bp_done", 100);
      chk("bp_ncmd", 64'(got.size()), 64'd8);
      if (got.size() == 8) chk("bp_last", 64'(got[7]), 64'h3000_0007);
      chk("bp_count", 64'(instr_count), 64'd8);

      // Throughput
      pulse_start(10'd200);
      wait_done("tp_done", 100);
      chk("tp_latency", 64'(first_valid - start_cyc), 64'd4);
      chk("tp_span", 64'(last_pop - first_pop), 64'd15);
      chk("tp_ncmd", 64'(got.size()), 64'd16);
      if (got.size() == 16) chk("tp_last", 64'(got[15]), 64'h5000_000F);

      // Overflow at top of address space
      pulse_start(10'd1020);
      wait_done("ovf_done", 100);
      chk("ovf_count", 64'(instr_count), 64'd4);
      chk("ovf_error", 64'(error), 64'd1);
      if (got.size() == 4) chk("ovf_cmd0", 64'(got[0]), 64'h7000_03FC);

      // Immediate HALT, with a start ignored while busy
      pulse_start(10'd500);
      chk("halt_err_clr", 64'(error), 64'd0);
      chk("halt_busy", 64'(busy), 64'd1);
      pulse_start(10'd0);
      wait_done("halt_done", 100);
      chk("halt_count", 64'(instr_count), 64'd0);
      chk("halt_valid_cycles", 64'(valid_cyc), 64'd0);
      repeat (3) @(negedge clk);
      chk("halt_stays_idle", 64'(busy), 64'd0);

      // Reset in the middle of a fetch
      pulse_start(10'd200);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_idle_outputs("midreset");
      @(negedge clk);
      rst = 1'b0;
      basic_run("rerun");

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
